dot_job_sequencer: RTL and testbench
====================================

DOT_JOB_SEQUENCER -- requirements
Module: dot_job_sequencer

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, 4, input job FIFO entries (power of 2, >=2); TIMEOUT_CYC, 40, max cycles waiting for dp_valid.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid / in_ready  input/output  1/1  job handshake; transfer when both high on a rising edge.
REQ-005 in_vec_a, in_vec_b  input  48 each  three packed FP16 lanes, [47:32]=x, [31:16]=y, [15:0]=z.
REQ-006 dp_en  output  1  one-cycle start pulse to the dot-product unit.
REQ-007 dp_vec_a, dp_vec_b  output  48 each  operands to the dot-product unit, registered.
REQ-008 dp_scalar / dp_valid  input  16/1  dot-product result and its completion strobe.
REQ-009 out_valid / out_ready  output/input  1/1  result handshake.
REQ-010 out_scalar  output  16  FP16 result, held stable while out_valid=1 and out_ready=0.
REQ-011 busy  output  1  high whenever FSM is not IDLE or the FIFO is non-empty.

Function
REQ-012 in_ready SHALL equal FIFO-not-full; a push while full is not accepted, even if a pop occurs in the same cycle.
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD.
REQ-014 IDLE: FIFO non-empty -> load dp_vec_a/b from FIFO head, pop, go to ISSUE; otherwise stay.
REQ-015 ISSUE: dp_en=1 for exactly this cycle, then WAIT; dp_en SHALL be 0 in every other state.
REQ-016 WAIT: on dp_valid, capture dp_scalar into out_scalar, go to HOLD.
REQ-017 HOLD: out_valid=1; on out_ready go to IDLE; out_valid SHALL be 0 in all other states.
REQ-018 dp_vec_a/b SHALL stay constant from ISSUE until the cycle after leaving WAIT; only one job is in flight at any time.
REQ-019 dp_valid outside WAIT SHALL be ignored (no state change, no capture).
REQ-020 Latency: a job accepted into an empty FIFO in IDLE at edge t reaches ISSUE at t+2; out_valid rises the edge after dp_valid is sampled in WAIT.
REQ-021 Jobs SHALL complete in acceptance order; the FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-022 While rst_n=0: state=IDLE, FIFO empty, in_ready=1, dp_en=0, dp_vec_a/b=0, out_valid=0, out_scalar=16'h0000, busy=0, timeout counter=0.
REQ-023 Reset asserted mid-job SHALL drop all queued and in-flight jobs; no result is produced after release.

Configuration
REQ-024 With macro DOT_SEQ_TIMEOUT_EN defined, WAIT SHALL count cycles from entry; if TIMEOUT_CYC cycles elapse without dp_valid, out_scalar=16'h7E00 (qNaN), go to HOLD, and sticky output err_timeout (1 bit, cleared only by reset) SHALL set.
REQ-025 Without DOT_SEQ_TIMEOUT_EN, WAIT SHALL wait indefinitely, and neither the counter nor the err_timeout port exists.

Structure
REQ-026 Package dot_seq_pkg SHALL hold the state enum, FP16 qNaN constant, lane-slice constants and parameter defaults.
REQ-027 The FIFO SHALL be a separate sub-module dot_seq_fifo (synchronous, registered-read head, full/empty flags).

Verification
REQ-028 a=(3C00,4000,4200), b=(3C00,3C00,3C00) with a 25-cycle dp model -> single dp_en pulse, out_scalar=16'h4600 (6.0).
REQ-029 Push 5 jobs back-to-back with out_ready=0 and FIFO_DEPTH=4 -> in_ready low after 4 accepts; the 5th transfers only after first pop; outputs in order.
REQ-030 Hold out_ready=0 for 10 cycles in HOLD -> out_scalar constant, no new dp_en, FIFO continues accepting until full.
REQ-031 Inject a stray dp_valid in IDLE and HOLD -> no capture, no state change.
REQ-032 DOT_SEQ_TIMEOUT_EN defined, dp model never responds -> after 40 WAIT cycles out_scalar=16'h7E00, err_timeout=1.
REQ-033 Assert rst_n=0 for 1 cycle mid-WAIT with 2 jobs queued -> all outputs at reset values; no out_valid after release until new jobs pushed.

Source files
------------

// File: rtl/dot_seq_pkg.sv
// Shared types and constants for the dot-product job sequencer.
package dot_seq_pkg;

  localparam int FP16_W = 16;
  localparam int VEC_W  = 3 * FP16_W;

  // Lane positions inside a packed 3-lane FP16 vector: {x, y, z}.
  localparam int LANE_X_LSB = 32;
  localparam int LANE_Y_LSB = 16;
  localparam int LANE_Z_LSB = 0;

  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_TIMEOUT_CYC = 40;

  localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;
  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_e;

  // One queued job: both operand vectors travel together through the FIFO.
  typedef struct packed {
    logic [VEC_W-1:0] vec_a;
    logic [VEC_W-1:0] vec_b;
  } dot_job_t;

endpackage

// File: rtl/dot_job_sequencer_if.sv
// Job, dot-product-unit and result handshakes of the sequencer.
// master = sequencer side, slave = environment side.
interface dot_job_sequencer_if;
  import dot_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [VEC_W-1:0]  in_vec_a;
  logic [VEC_W-1:0]  in_vec_b;

  logic              dp_en;
  logic [VEC_W-1:0]  dp_vec_a;
  logic [VEC_W-1:0]  dp_vec_b;
  logic [FP16_W-1:0] dp_scalar;
  logic              dp_valid;

  logic              out_valid;
  logic              out_ready;
  logic [FP16_W-1:0] out_scalar;

  logic              busy;

  modport master (
    input  in_valid, in_vec_a, in_vec_b, dp_scalar, dp_valid, out_ready,
    output in_ready, dp_en, dp_vec_a, dp_vec_b, out_valid, out_scalar, busy
  );

  modport slave (
    output in_valid, in_vec_a, in_vec_b, dp_scalar, dp_valid, out_ready,
    input  in_ready, dp_en, dp_vec_a, dp_vec_b, out_valid, out_scalar, busy
  );

endinterface

// File: rtl/dot_seq_fifo.sv
// Job FIFO with a registered head: entries live in an array and the oldest
// one is copied into a head register one cycle after it becomes available.
// The occupancy count includes the head, so full/empty cover the whole queue.
module dot_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             head_valid_reg;
  logic [WIDTH-1:0] head_data_reg;

  logic             push_ok;
  logic             pop_ok;
  logic             refill;
  logic [CNT_W-1:0] mem_count;

  // A push while full is refused even if the head is popped in the same cycle.
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && head_valid_reg;
  assign mem_count = count_reg - CNT_W'(head_valid_reg);
  assign refill    = (mem_count != '0) && (!head_valid_reg || pop_ok);

  assign head_valid = head_valid_reg;
  assign head_data  = head_data_reg;

  // Storage write port; pointer wraps naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers, occupancy and the registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
      head_data_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (refill) begin
        head_data_reg  <= mem[rd_ptr_reg];
        head_valid_reg <= 1'b1;
        rd_ptr_reg     <= rd_ptr_reg + PTR_W'(1);
      end else if (pop_ok) begin
        head_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dot_job_sequencer.sv
// Sequences queued dot-product jobs one at a time through an external
// dot-product unit: IDLE -> ISSUE (start pulse) -> WAIT (result) -> HOLD.
// Optional feature: define DOT_SEQ_TIMEOUT_EN to bound WAIT to TIMEOUT_CYC
// cycles, returning qNaN and setting the sticky err_timeout output.
module dot_job_sequencer
  import dot_seq_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
`ifdef DOT_SEQ_TIMEOUT_EN
  output logic err_timeout,
`endif
  dot_job_sequencer_if.master bus
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("dot_job_sequencer: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
  end

  seq_state_e        state_reg;
  seq_state_e        state_next;
  logic [VEC_W-1:0]  dp_vec_a_reg;
  logic [VEC_W-1:0]  dp_vec_b_reg;
  logic [FP16_W-1:0] out_scalar_reg;

  logic     fifo_full;
  logic     fifo_empty;
  logic     head_valid;
  logic     pop;
  dot_job_t push_job;
  dot_job_t head_job;
  logic     timeout_hit;

  assign push_job.vec_a = bus.in_vec_a;
  assign push_job.vec_b = bus.in_vec_b;

  dot_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(dot_job_t))
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (bus.in_valid),
    .push_data  (push_job),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_valid (head_valid),
    .head_data  (head_job)
  );

`ifdef DOT_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_reg;
  logic            err_timeout_reg;

  assign timeout_hit = (state_reg == ST_WAIT) && !bus.dp_valid &&
                       (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));
  assign err_timeout = err_timeout_reg;

  // Counts cycles spent in the current WAIT visit; zero everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg <= '0;
    end else if (state_reg == ST_WAIT && state_next == ST_WAIT) begin
      to_cnt_reg <= to_cnt_reg + TO_W'(1);
    end else begin
      to_cnt_reg <= '0;
    end
  end

  // Sticky timeout flag, only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout_reg <= 1'b0;
    end else if (timeout_hit) begin
      err_timeout_reg <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; pop the FIFO head only when a new job is launched.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (head_valid) begin
          pop        = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (bus.dp_valid || timeout_hit) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand and result registers; dp_valid only matters while in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_vec_a_reg   <= '0;
      dp_vec_b_reg   <= '0;
      out_scalar_reg <= FP16_ZERO;
    end else begin
      if (pop) begin
        dp_vec_a_reg <= head_job.vec_a;
        dp_vec_b_reg <= head_job.vec_b;
      end
      if (state_reg == ST_WAIT && bus.dp_valid) begin
        out_scalar_reg <= bus.dp_scalar;
      end else if (timeout_hit) begin
        out_scalar_reg <= FP16_QNAN;
      end
    end
  end

  assign bus.in_ready   = !fifo_full;
  assign bus.dp_en      = (state_reg == ST_ISSUE);
  assign bus.dp_vec_a   = dp_vec_a_reg;
  assign bus.dp_vec_b   = dp_vec_b_reg;
  assign bus.out_valid  = (state_reg == ST_HOLD);
  assign bus.out_scalar = out_scalar_reg;
  assign bus.busy       = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_dot_job_sequencer.sv
// Directed bench for dot_job_sequencer with a behavioural dot-product unit.
// Build with DOT_SEQ_TIMEOUT_EN defined to also exercise the WAIT timeout.
`timescale 1ns/1ps
module tb_dot_job_sequencer;
  import dot_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dot_job_sequencer_if bus();
`ifdef DOT_SEQ_TIMEOUT_EN
  logic err_timeout;
`endif

  dot_job_sequencer #(
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (40)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef DOT_SEQ_TIMEOUT_EN
    .err_timeout (err_timeout),
`endif
    .bus         (bus)
  );

  // Dot-product unit model: answers dp_lat edges after sampling dp_en.
  logic        model_pend;
  logic        model_valid;
  int          model_cnt;
  logic [15:0] model_scalar;
  int          dp_lat = 3;
  logic        dp_mute = 1'b0;
  int          dp_en_cnt = 0;
  logic        stray_valid = 1'b0;

  assign bus.dp_valid  = model_valid | stray_valid;
  assign bus.dp_scalar = stray_valid ? 16'hDEAD : model_scalar;

  // Known FP16 answer for the reference vectors, z-lane XOR for tagged jobs.
  function automatic logic [15:0] dp_result(input logic [47:0] a, input logic [47:0] b);
    if (a == 48'h3C00_4000_4200 && b == 48'h3C00_3C00_3C00) return 16'h4600;
    return a[15:0] ^ b[15:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_pend   <= 1'b0;
      model_valid  <= 1'b0;
      model_cnt    <= 0;
      model_scalar <= 16'h0;
    end else begin
      model_valid <= 1'b0;
      if (bus.dp_en) dp_en_cnt <= dp_en_cnt + 1;
      if (bus.dp_en && !dp_mute) begin
        model_pend <= 1'b1;
        model_cnt  <= dp_lat - 1;
      end else if (model_pend) begin
        if (model_cnt == 0) begin
          model_pend   <= 1'b0;
          model_valid  <= 1'b1;
          model_scalar <= dp_result(bus.dp_vec_a, bus.dp_vec_b);
        end else begin
          model_cnt <= model_cnt - 1;
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] tag_a(input logic [15:0] k);
    return {16'h3C00, 16'h3C00, 16'h1000 + k};
  endfunction

  localparam logic [47:0] TAG_B = 48'h0000_0000_5000;

  task automatic push_job(input logic [47:0] a, input logic [47:0] b, input string tag);
    logic rdy;
    bit   done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_vec_a = a;
    bus.in_vec_b = b;
    for (int i = 0; i < 200 && !done; i++) begin
      rdy = bus.in_ready;
      tick();
      if (rdy) done = 1'b1;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_accept"}, done, 1);
  endtask

  task automatic wait_outv(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (bus.out_valid) seen = 1'b1;
      else tick();
    end
    chk({tag, "_outv_seen"}, seen, 1);
  endtask

  task automatic wait_dp_en(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (bus.dp_en) seen = 1'b1;
      else tick();
    end
    chk({tag, "_dp_en_seen"}, seen, 1);
  endtask

  task automatic wait_out(input logic [15:0] exp, input string tag);
    wait_outv(tag);
    chk({tag, "_scalar"}, bus.out_scalar, exp);
    $display("job %s result=%h expected=%h", tag, bus.out_scalar, exp);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          en0;
    bit          seen;
    bit          changed;
    bit          rdy_seen;
    logic [15:0] snap;
    int          n;

    bus.in_valid  = 1'b0;
    bus.in_vec_a  = '0;
    bus.in_vec_b  = '0;
    bus.out_ready = 1'b0;

    // Reset values.
    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_dp_en", bus.dp_en, 0);
    chk("rst_dp_vec_a", bus.dp_vec_a, 48'h0);
    chk("rst_dp_vec_b", bus.dp_vec_b, 48'h0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_scalar", bus.out_scalar, 16'h0000);
    chk("rst_busy", bus.busy, 0);
`ifdef DOT_SEQ_TIMEOUT_EN
    chk("rst_err_timeout", err_timeout, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Reference dot product with a 25-cycle unit, plus latency to ISSUE.
    dp_lat = 25;
    base = dp_en_cnt;
    push_job(48'h3C00_4000_4200, 48'h3C00_3C00_3C00, "ref");
    chk("lat_t0_dp_en", bus.dp_en, 0);
    chk("lat_t0_busy", bus.busy, 1);
    tick();
    chk("lat_t1_dp_en", bus.dp_en, 0);
    tick();
    chk("lat_t2_dp_en", bus.dp_en, 1);
    chk("ref_dp_vec_a", bus.dp_vec_a, 48'h3C00_4000_4200);
    chk("ref_dp_vec_b", bus.dp_vec_b, 48'h3C00_3C00_3C00);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus.dp_valid) seen = 1'b1;
      else tick();
    end
    chk("ref_dp_valid_seen", seen, 1);
    chk("ref_outv_before_edge", bus.out_valid, 0);
    chk("ref_vec_held", bus.dp_vec_a, 48'h3C00_4000_4200);
    tick();
    chk("ref_outv_after_edge", bus.out_valid, 1);
    wait_out(16'h4600, "ref");
    chk("ref_dp_en_pulses", dp_en_cnt - base, 1);
    chk("ref_idle_outv", bus.out_valid, 0);
    chk("ref_idle_busy", bus.busy, 0);

    // Backpressure: job0 parked in HOLD, 4 more fill the FIFO, 5th waits.
    dp_lat = 3;
    base = dp_en_cnt;
    push_job(tag_a(16'd0), TAG_B, "j0");
    wait_outv("j0");
    chk("j0_scalar", bus.out_scalar, 16'h4000);
    en0 = dp_en_cnt;
    push_job(tag_a(16'd1), TAG_B, "j1");
    push_job(tag_a(16'd2), TAG_B, "j2");
    push_job(tag_a(16'd3), TAG_B, "j3");
    push_job(tag_a(16'd4), TAG_B, "j4");
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_busy", bus.busy, 1);
    bus.in_valid = 1'b1;
    bus.in_vec_a = tag_a(16'd5);
    bus.in_vec_b = TAG_B;
    changed  = 1'b0;
    rdy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      tick();
      if (bus.out_scalar !== 16'h4000) changed = 1'b1;
    end
    chk("hold_scalar_stable", changed, 0);
    chk("hold_no_dp_en", dp_en_cnt - en0, 0);
    chk("hold_out_valid", bus.out_valid, 1);
    chk("j5_blocked", rdy_seen, 0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    push_job(tag_a(16'd5), TAG_B, "j5");
    wait_out(16'h4001, "j1");
    wait_out(16'h4002, "j2");
    wait_out(16'h4003, "j3");
    wait_out(16'h4004, "j4");
    wait_out(16'h4005, "j5");
    chk("order_dp_en_pulses", dp_en_cnt - base, 6);

    // Stray dp_valid in IDLE and in HOLD.
    tick();
    stray_valid = 1'b1;
    tick();
    stray_valid = 1'b0;
    chk("stray_idle_outv", bus.out_valid, 0);
    chk("stray_idle_busy", bus.busy, 0);
    chk("stray_idle_scalar", bus.out_scalar, 16'h4005);
    push_job(tag_a(16'd6), TAG_B, "j6");
    wait_outv("j6");
    stray_valid = 1'b1;
    tick();
    stray_valid = 1'b0;
    chk("stray_hold_scalar", bus.out_scalar, 16'h4006);
    chk("stray_hold_outv", bus.out_valid, 1);
    tick();
    chk("stray_hold_outv2", bus.out_valid, 1);
    wait_out(16'h4006, "j6");

`ifdef DOT_SEQ_TIMEOUT_EN
    // Unit never answers: qNaN after 40 WAIT cycles and sticky error.
    dp_mute = 1'b1;
    push_job(tag_a(16'd7), TAG_B, "j7");
    wait_dp_en("j7");
    n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("to_edges_to_outv", n, 41);
    chk("to_scalar", bus.out_scalar, 16'h7E00);
    chk("to_err", err_timeout, 1);
    wait_out(16'h7E00, "j7");
    tick();
    chk("to_err_sticky", err_timeout, 1);
    dp_mute = 1'b0;
`endif

    // Reset mid-WAIT with two jobs queued.
    dp_mute = 1'b1;
    push_job(tag_a(16'd8), TAG_B, "j8");
    wait_dp_en("j8");
    tick();
    push_job(tag_a(16'd9), TAG_B, "j9");
    push_job(tag_a(16'd10), TAG_B, "j10");
    repeat (3) tick();
    chk("mid_wait_outv", bus.out_valid, 0);
    chk("mid_wait_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst2_in_ready", bus.in_ready, 1);
    chk("rst2_dp_en", bus.dp_en, 0);
    chk("rst2_dp_vec_a", bus.dp_vec_a, 48'h0);
    chk("rst2_dp_vec_b", bus.dp_vec_b, 48'h0);
    chk("rst2_out_valid", bus.out_valid, 0);
    chk("rst2_out_scalar", bus.out_scalar, 16'h0000);
    chk("rst2_busy", bus.busy, 0);
`ifdef DOT_SEQ_TIMEOUT_EN
    chk("rst2_err_timeout", err_timeout, 0);
`endif
    tick();
    rst_n = 1'b1;
    dp_mute = 1'b0;
    base = dp_en_cnt;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.out_valid || bus.dp_en) seen = 1'b1;
    end
    chk("post_rst_quiet", seen, 0);
    chk("post_rst_dp_en", dp_en_cnt - base, 0);
    chk("post_rst_busy", bus.busy, 0);
    push_job(tag_a(16'd11), TAG_B, "j11");
    wait_out(16'h400B, "j11");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
